bus_mem_io: RTL and testbench
=============================

# bus_mem_io

Parametrised system-side responder for the CPU's external buses. It provides a word-organised RAM on the memory bus (ABUS/DBUS, nMREQ/nRD/nWR, byte enables) and a bank of 8-bit peripheral ports on the I/O bus (IOAD/IODB, nPREQ/nPRD/nPWR). It replaces hand-driven data in simulation and serves as the on-chip memory/IO subsystem. It adds programmable wait states with an nREADY handshake, generic data width and byte lanes, and configurable memory depth and port count.

## Interface
- AW, 16, address width
- DW, 16, data width; multiple of 8; NB = DW/8 byte lanes
- DEPTH, 256, words of RAM (power of 2)
- NPORTS, 4, I/O ports; IOAD width PW = max(1, clog2(NPORTS))
- WAIT, 1, memory wait states, 0..7
- CLK  in  1  clock, all state on rising edge
- nRST  in  1  asynchronous, active-low reset
- ABUS  in  AW  byte address
- DBUS  inout  DW  data; driven only during read data phase, else Z
- nMREQ, nRD, nWR  in  1 each  memory request/read/write strobes, active-low
- nBE  in  NB  byte-lane enables, active-low; lane 0 = nBLE, lane 1 = nBHE
- nREADY  out  1  low = data phase (read data valid / write accepted)
- ERR  out  1  sticky: nRD and nWR both low with nMREQ low
- IOAD  in  PW  port select
- IODB  inout  8  port data; driven only while nPREQ=0 and nPRD=0
- nPREQ, nPRD, nPWR  in  1 each  I/O strobes, active-low
- PIN  in  8*NPORTS  external port inputs, asynchronous
- POUT  out  8*NPORTS  port output registers

## Operation
- Word index = ABUS[AW-1:log2(NB)] mod DEPTH. High address bits wrap silently.
- Memory FSM states:
  - IDLE: on an edge with nMREQ=0 and exactly one of nRD/nWR low, latch index, nBE, and direction. If WAIT=0, go to DATA; otherwise go to WT and load cnt=WAIT-1.
  - WT: decrement cnt. At cnt=0, go to DATA.
  - DATA: nREADY=0.
    - Read: register RAM word; DBUS drives the registered word; disabled lanes drive 0.
    - Write: on DATA entry, write the DBUS lanes whose nBE=0, once.
    - Go to HOLD.
  - HOLD: nREADY=0. DBUS stays driven for reads. Return to IDLE when nMREQ=1 or the active strobe=1.
- If the strobes are released during WT: abort to IDLE, no write, nREADY stays 1.
- nRD=nWR=0 with nMREQ=0: transaction ignored, ERR←1 until reset.
- I/O ports:
  - PIN passes through a 2-flop synchronizer per bit.
  - Read: IODB = sync_PIN[IOAD], combinational while nPREQ=0 and nPRD=0.
  - Write: on an edge with nPREQ=0 and nPWR=0, POUT[IOAD] ← IODB.
  - IOAD ≥ NPORTS: reads return 8'hFF, writes are dropped.
  - nPRD=nPWR=0: the write takes effect and IODB is not driven.
- Memory and I/O paths are independent and may be active in the same cycle.

## Timing
- Reset values: FSM=IDLE, nREADY=1, DBUS=Z, IODB=Z, ERR=0, POUT=0, synchronizers=0. RAM contents are not reset.
- Reset mid-transaction: immediate return to IDLE and bus release. A write not yet at DATA is lost.
- Read latency: strobe sampled at edge 0; nREADY falls after edge 1+WAIT; data is valid with nREADY.
- Write commit: at the edge entering DATA, 1+WAIT edges after the strobe is sampled.
- Back-to-back: a new request needs at least one sampled IDLE cycle with strobes high.
- PIN to IODB: 2 cycles.
- POUT update: 1 edge after the nPWR sample.

## Structure
- Package bus_pkg holds:
  - memory FSM state encoding (IDLE, WT, DATA, HOLD)
  - default widths: AW, DW, port width 8
  - the 8'hFF unmapped-port value
- Sub-module io_port_bank: synchronizers, POUT registers, IODB mux.
- Top level holds the RAM array, the FSM, and the wait counter.

## Test plan
- Reset, WAIT=1: write 16'h407F to ABUS=0 with nBE=00, then read ABUS=0. Required: nREADY low 2 cycles after the request; DBUS=16'h407F.
- Byte lanes: write 16'hAAAA with nBE=10 (low lane only) over 16'h1234 at ABUS=2, then read. Required: 16'h12AA.
- Wrap and abort:
  - DEPTH=256: write ABUS=16'h0200, read ABUS=0. Required: same word.
  - WAIT=3: release nWR during WT. Required: no write, nREADY stays 1.
- I/O: PIN[0]=8'hA7; nPREQ=0, nPRD=0, IOAD=0 after 2 cycles. Required: IODB=8'hA7. Write 8'h7E to port 1. Required: POUT[15:8]=8'h7E next edge. IOAD=3 with NPORTS=3. Required: read 8'hFF.
- Error and reset:
  - nRD=nWR=0 with nMREQ=0. Required: ERR=1, RAM unchanged.
  - Assert nRST during HOLD. Required: DBUS=Z, nREADY=1, POUT=0 immediately, RAM retained.

Source files
------------

// File: rtl/bus_mem_io_pkg.sv
// Shared types and constants for the bus_mem_io memory/IO responder.
// Holds the memory FSM encoding, default widths and the unmapped-port value.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WT,
    DATA,
    HOLD
  } memState_e;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;
  localparam int PORT_W = 8;

  localparam logic [PORT_W-1:0] UNMAPPED_PORT = 8'hFF;

  // A single port still needs a one-bit select so the bus never collapses to zero width.
  function automatic int ioPortWidth(input int nPorts);
    return (nPorts > 1) ? $clog2(nPorts) : 1;
  endfunction

endpackage

// File: rtl/bus_mem_io_if.sv
// Unidirectional strobes, addresses and status of the CPU memory and I/O buses.
// The shared data lines stay plain inout ports on the responder.
interface bus_mem_io_if #(
  parameter int AW = 16,
  parameter int NB = 2,
  parameter int PW = 2
);

  logic [AW-1:0] ABUS;
  logic          nMREQ;
  logic          nRD;
  logic          nWR;
  logic [NB-1:0] nBE;
  logic          nREADY;
  logic          ERR;
  logic [PW-1:0] IOAD;
  logic          nPREQ;
  logic          nPRD;
  logic          nPWR;

  modport master (
    output ABUS, nMREQ, nRD, nWR, nBE, IOAD, nPREQ, nPRD, nPWR,
    input  nREADY, ERR
  );

  modport slave (
    input  ABUS, nMREQ, nRD, nWR, nBE, IOAD, nPREQ, nPRD, nPWR,
    output nREADY, ERR
  );

endinterface

// File: rtl/bus_mem_io_io_port_bank.sv
// Bank of 8-bit peripheral ports: synchronised inputs, output registers and the
// IODB read mux. Tristate control is left to the top level.
module io_port_bank
  import bus_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int PW     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PW-1:0]            ioad_i,
  input  logic                     npreq_i,
  input  logic                     nprd_i,
  input  logic                     npwr_i,
  input  logic [PORT_W-1:0]        iodb_i,
  input  logic [PORT_W*NPORTS-1:0] pin_i,
  output logic [PORT_W*NPORTS-1:0] pout_o,
  output logic [PORT_W-1:0]        iodb_o,
  output logic                     iodbOe_o
);

  logic [PORT_W*NPORTS-1:0] sync1_q;
  logic [PORT_W*NPORTS-1:0] sync2_q;
  logic [PORT_W*NPORTS-1:0] pout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pout_q  <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      if (!npreq_i && !npwr_i) begin
        for (int p = 0; p < NPORTS; p++) begin
          if (int'(ioad_i) == p) begin
            pout_q[p*PORT_W +: PORT_W] <= iodb_i;
          end
        end
      end
    end
  end

  // Selects beyond the populated ports fall through to the unmapped value.
  always_comb begin
    iodb_o = UNMAPPED_PORT;
    for (int p = 0; p < NPORTS; p++) begin
      if (int'(ioad_i) == p) begin
        iodb_o = sync2_q[p*PORT_W +: PORT_W];
      end
    end
  end

  // A simultaneous write strobe wins: the CPU owns IODB then.
  assign iodbOe_o = !npreq_i && !nprd_i && npwr_i;
  assign pout_o   = pout_q;

endmodule

// File: rtl/bus_mem_io.sv
// System-side responder: word RAM with programmable wait states on the memory
// bus plus a peripheral port bank on the I/O bus.
module bus_mem_io
  import bus_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int DEPTH  = 256,
  parameter int NPORTS = 4,
  parameter int WAIT   = 1
) (
  input  logic                     CLK,
  input  logic                     nRST,
  bus_mem_io_if.slave              bus,
  inout  wire  [DW-1:0]            DBUS,
  inout  wire  [PORT_W-1:0]        IODB,
  input  logic [PORT_W*NPORTS-1:0] PIN,
  output logic [PORT_W*NPORTS-1:0] POUT
);

  localparam int NB = DW / 8;
  localparam int IW = $clog2(DEPTH);
  localparam int LB = (NB > 1) ? $clog2(NB) : 0;
  localparam int PW = ioPortWidth(NPORTS);
  localparam logic [2:0] WAIT_INIT = 3'((WAIT > 0) ? WAIT - 1 : 0);

  logic [DW-1:0] mem [DEPTH];

  memState_e     state_q;
  logic [IW-1:0] idx_q;
  logic [NB-1:0] nbe_q;
  logic          isRead_q;
  logic [2:0]    cnt_q;
  logic [DW-1:0] rdData_q;
  logic          nReady_q;
  logic          drive_q;
  logic          err_q;

  logic [DW-1:0] beMask;
  logic [DW-1:0] memWord;
  logic [DW-1:0] dbusIn;
  logic          reqRd;
  logic          reqWr;
  logic          reqBoth;
  logic          released;

  assign reqRd    = !bus.nMREQ && !bus.nRD &&  bus.nWR;
  assign reqWr    = !bus.nMREQ &&  bus.nRD && !bus.nWR;
  assign reqBoth  = !bus.nMREQ && !bus.nRD && !bus.nWR;
  assign released = bus.nMREQ || (isRead_q ? bus.nRD : bus.nWR);
  assign memWord  = mem[idx_q];
  assign dbusIn   = DBUS;

  always_comb begin
    beMask = '0;
    for (int l = 0; l < NB; l++) begin
      beMask[l*8 +: 8] = {8{~nbe_q[l]}};
    end
  end

  // Memory transaction FSM; every bus-visible output is a register of this block.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      nbe_q    <= '1;
      isRead_q <= 1'b0;
      cnt_q    <= '0;
      rdData_q <= '0;
      nReady_q <= 1'b1;
      drive_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (reqBoth) begin
        err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (reqRd || reqWr) begin
            idx_q    <= IW'(bus.ABUS >> LB);
            nbe_q    <= bus.nBE;
            isRead_q <= reqRd;
            if (WAIT == 0) begin
              state_q <= DATA;
            end else begin
              state_q <= WT;
              cnt_q   <= WAIT_INIT;
            end
          end
        end
        WT: begin
          if (released) begin
            state_q <= IDLE;
          end else if (cnt_q == '0) begin
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        DATA: begin
          if (isRead_q) begin
            rdData_q <= memWord & beMask;
          end
          nReady_q <= 1'b0;
          drive_q  <= isRead_q;
          state_q  <= HOLD;
        end
        HOLD: begin
          if (released) begin
            state_q  <= IDLE;
            nReady_q <= 1'b1;
            drive_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM contents survive reset, so the array has no reset branch.
  always_ff @(posedge CLK) begin
    if (state_q == DATA && !isRead_q) begin
      for (int l = 0; l < NB; l++) begin
        if (!nbe_q[l]) begin
          mem[idx_q][l*8 +: 8] <= dbusIn[l*8 +: 8];
        end
      end
    end
  end

  assign DBUS       = drive_q ? rdData_q : {DW{1'bz}};
  assign bus.nREADY = nReady_q;
  assign bus.ERR    = err_q;

  logic [PORT_W-1:0] iodbOut;
  logic              iodbOe;

  io_port_bank #(
    .NPORTS (NPORTS),
    .PW     (PW)
  ) u_io_port_bank (
    .clk      (CLK),
    .rst_n    (nRST),
    .ioad_i   (bus.IOAD),
    .npreq_i  (bus.nPREQ),
    .nprd_i   (bus.nPRD),
    .npwr_i   (bus.nPWR),
    .iodb_i   (IODB),
    .pin_i    (PIN),
    .pout_o   (POUT),
    .iodb_o   (iodbOut),
    .iodbOe_o (iodbOe)
  );

  assign IODB = iodbOe ? iodbOut : {PORT_W{1'bz}};

endmodule

// File: tb/tb_bus_mem_io.sv
// Directed bench for bus_mem_io: instance A (WAIT=1, 4 ports) and instance B
// (WAIT=3, 3 ports). Undriven data lines are pulled to a known level.
module tb_bus_mem_io;

  logic CLK;
  logic nRST;

  bus_mem_io_if #(.AW(16), .NB(2), .PW(2)) busA ();
  bus_mem_io_if #(.AW(16), .NB(2), .PW(2)) busB ();

  wire  [15:0] DBUS_A;
  wire  [15:0] DBUS_B;
  wire  [7:0]  IODB_A;
  wire  [7:0]  IODB_B;
  logic [15:0] tbDbusA, tbDbusB;
  logic        tbDbusEnA, tbDbusEnB;
  logic [7:0]  tbIodbA, tbIodbB;
  logic        tbIodbEnA, tbIodbEnB;
  logic [31:0] PIN_A;
  logic [31:0] POUT_A;
  logic [23:0] PIN_B;
  logic [23:0] POUT_B;

  int testsRun;
  int testsFailed;

  assign DBUS_A = tbDbusEnA ? tbDbusA : 16'bz;
  assign DBUS_B = tbDbusEnB ? tbDbusB : 16'bz;
  assign IODB_A = tbIodbEnA ? tbIodbA : 8'bz;
  assign IODB_B = tbIodbEnB ? tbIodbB : 8'bz;

  // A released DBUS/IODB_A reads all ones; a released IODB_B reads zero so it
  // cannot be confused with the unmapped-port value.
  for (genvar i = 0; i < 16; i++) begin : g_pullDbus
    pullup puA (DBUS_A[i]);
    pullup puB (DBUS_B[i]);
  end
  for (genvar i = 0; i < 8; i++) begin : g_pullIodb
    pullup   puA (IODB_A[i]);
    pulldown pdB (IODB_B[i]);
  end

  bus_mem_io #(.AW(16), .DW(16), .DEPTH(256), .NPORTS(4), .WAIT(1)) dutA (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (busA),
    .DBUS (DBUS_A),
    .IODB (IODB_A),
    .PIN  (PIN_A),
    .POUT (POUT_A)
  );

  bus_mem_io #(.AW(16), .DW(16), .DEPTH(256), .NPORTS(3), .WAIT(3)) dutB (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (busB),
    .DBUS (DBUS_B),
    .IODB (IODB_B),
    .PIN  (PIN_B),
    .POUT (POUT_B)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic readyOf(input bit sel);
    return sel ? busB.nREADY : busA.nREADY;
  endfunction

  function automatic logic [15:0] dbusOf(input bit sel);
    return sel ? DBUS_B : DBUS_A;
  endfunction

  task automatic driveMem(input bit sel, input logic [15:0] addr, input logic [1:0] nbe,
                          input logic mreqN, input logic rdN, input logic wrN);
    if (sel) begin
      busB.ABUS = addr; busB.nBE = nbe; busB.nMREQ = mreqN; busB.nRD = rdN; busB.nWR = wrN;
    end else begin
      busA.ABUS = addr; busA.nBE = nbe; busA.nMREQ = mreqN; busA.nRD = rdN; busA.nWR = wrN;
    end
  endtask

  task automatic driveData(input bit sel, input logic en, input logic [15:0] data);
    if (sel) begin
      tbDbusB = data; tbDbusEnB = en;
    end else begin
      tbDbusA = data; tbDbusEnA = en;
    end
  endtask

  // cyc = edges after the sampling edge until nREADY is seen low, -1 on timeout.
  task automatic memWrite(input bit sel, input logic [15:0] addr, input logic [15:0] data,
                          input logic [1:0] nbe, output int cyc);
    cyc = -1;
    driveData(sel, 1'b1, data);
    driveMem(sel, addr, nbe, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (readyOf(sel) == 1'b0) begin
        cyc = i;
        break;
      end
    end
    driveMem(sel, addr, 2'b11, 1'b1, 1'b1, 1'b1);
    driveData(sel, 1'b0, 16'h0000);
    tick();
    tick();
  endtask

  task automatic memRead(input bit sel, input logic [15:0] addr, input logic [1:0] nbe,
                         output logic [15:0] data, output int cyc);
    cyc  = -1;
    data = 16'hxxxx;
    driveMem(sel, addr, nbe, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (readyOf(sel) == 1'b0) begin
        cyc  = i;
        data = dbusOf(sel);
        break;
      end
    end
    driveMem(sel, addr, 2'b11, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
  endtask

  task automatic test_reset();
    logic [15:0] d;
    nRST = 1'b0;
    tick();
    tick();
    testsRun++;
    if (busA.nREADY !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL reset_nready_a got=%b exp=1", busA.nREADY);
    end
    testsRun++;
    if (busA.ERR !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL reset_err_a got=%b exp=0", busA.ERR);
    end
    testsRun++;
    if (POUT_A !== 32'h0) begin
      testsFailed++; $display("[TB] FAIL reset_pout_a got=%h exp=00000000", POUT_A);
    end
    d = DBUS_A;
    testsRun++;
    if (d !== 16'hFFFF) begin
      testsFailed++; $display("[TB] FAIL reset_dbus_released got=%h exp=ffff", d);
    end
    testsRun++;
    if (IODB_A !== 8'hFF) begin
      testsFailed++; $display("[TB] FAIL reset_iodb_released got=%h exp=ff", IODB_A);
    end
    testsRun++;
    if (busB.nREADY !== 1'b1 || POUT_B !== 24'h0) begin
      testsFailed++; $display("[TB] FAIL reset_b got nready=%b pout=%h exp nready=1 pout=000000",
                              busB.nREADY, POUT_B);
    end
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    logic [15:0] d;
    int cyc;
    memWrite(1'b0, 16'h0000, 16'h407F, 2'b00, cyc);
    testsRun++;
    if (cyc !== 2) begin
      testsFailed++; $display("[TB] FAIL write_latency got=%0d exp=2", cyc);
    end
    memRead(1'b0, 16'h0000, 2'b00, d, cyc);
    testsRun++;
    if (cyc !== 2) begin
      testsFailed++; $display("[TB] FAIL read_latency got=%0d exp=2", cyc);
    end
    testsRun++;
    if (d !== 16'h407F) begin
      testsFailed++; $display("[TB] FAIL read_data got=%h exp=407f", d);
    end
  endtask

  task automatic test_byte_lanes();
    logic [15:0] d;
    int cyc;
    memWrite(1'b0, 16'h0002, 16'h1234, 2'b00, cyc);
    memWrite(1'b0, 16'h0002, 16'hAAAA, 2'b10, cyc);
    memRead(1'b0, 16'h0002, 2'b00, d, cyc);
    testsRun++;
    if (d !== 16'h12AA) begin
      testsFailed++; $display("[TB] FAIL low_lane_write got=%h exp=12aa", d);
    end
    memWrite(1'b0, 16'h0002, 16'h5500, 2'b01, cyc);
    memRead(1'b0, 16'h0002, 2'b00, d, cyc);
    testsRun++;
    if (d !== 16'h55AA) begin
      testsFailed++; $display("[TB] FAIL high_lane_write got=%h exp=55aa", d);
    end
    memRead(1'b0, 16'h0002, 2'b01, d, cyc);
    testsRun++;
    if (d !== 16'h5500) begin
      testsFailed++; $display("[TB] FAIL read_lane_masked got=%h exp=5500", d);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] d;
    int cyc;
    memWrite(1'b0, 16'h0200, 16'hBEEF, 2'b00, cyc);
    memRead(1'b0, 16'h0000, 2'b00, d, cyc);
    testsRun++;
    if (d !== 16'hBEEF) begin
      testsFailed++; $display("[TB] FAIL addr_wrap got=%h exp=beef", d);
    end
    memRead(1'b0, 16'h0003, 2'b00, d, cyc);
    testsRun++;
    if (d !== 16'h55AA) begin
      testsFailed++; $display("[TB] FAIL odd_byte_addr got=%h exp=55aa", d);
    end
  endtask

  task automatic test_abort();
    logic [15:0] d;
    logic        sawLow;
    int cyc;
    memWrite(1'b1, 16'h0004, 16'h1111, 2'b00, cyc);
    testsRun++;
    if (cyc !== 4) begin
      testsFailed++; $display("[TB] FAIL wait3_write_latency got=%0d exp=4", cyc);
    end
    sawLow = 1'b0;
    driveData(1'b1, 1'b1, 16'h2222);
    driveMem(1'b1, 16'h0004, 2'b00, 1'b0, 1'b1, 1'b0);
    tick();
    if (busB.nREADY == 1'b0) sawLow = 1'b1;
    tick();
    if (busB.nREADY == 1'b0) sawLow = 1'b1;
    driveMem(1'b1, 16'h0004, 2'b11, 1'b1, 1'b1, 1'b1);
    driveData(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busB.nREADY == 1'b0) sawLow = 1'b1;
    end
    testsRun++;
    if (sawLow !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL abort_nready got=low exp=stays high");
    end
    memRead(1'b1, 16'h0004, 2'b00, d, cyc);
    testsRun++;
    if (d !== 16'h1111) begin
      testsFailed++; $display("[TB] FAIL abort_no_write got=%h exp=1111", d);
    end
    testsRun++;
    if (cyc !== 4) begin
      testsFailed++; $display("[TB] FAIL wait3_read_latency got=%0d exp=4", cyc);
    end
  endtask

  task automatic test_io();
    busA.IOAD = 2'd0; busA.nPREQ = 1'b0; busA.nPRD = 1'b0; busA.nPWR = 1'b1;
    PIN_A = 32'h0000_00A7;
    #1;
    testsRun++;
    if (IODB_A !== 8'h00) begin
      testsFailed++; $display("[TB] FAIL pin_sync_0 got=%h exp=00", IODB_A);
    end
    tick();
    testsRun++;
    if (IODB_A !== 8'h00) begin
      testsFailed++; $display("[TB] FAIL pin_sync_1 got=%h exp=00", IODB_A);
    end
    tick();
    testsRun++;
    if (IODB_A !== 8'hA7) begin
      testsFailed++; $display("[TB] FAIL pin_sync_2 got=%h exp=a7", IODB_A);
    end
    busA.nPRD = 1'b1; busA.IOAD = 2'd1;
    tbIodbA = 8'h7E; tbIodbEnA = 1'b1; busA.nPWR = 1'b0;
    #1;
    testsRun++;
    if (POUT_A !== 32'h0) begin
      testsFailed++; $display("[TB] FAIL pout_before_edge got=%h exp=00000000", POUT_A);
    end
    tick();
    testsRun++;
    if (POUT_A !== 32'h0000_7E00) begin
      testsFailed++; $display("[TB] FAIL pout_port1 got=%h exp=00007e00", POUT_A);
    end
    busA.IOAD = 2'd2; busA.nPRD = 1'b0; tbIodbA = 8'h3C;
    tick();
    testsRun++;
    if (POUT_A !== 32'h003C_7E00) begin
      testsFailed++; $display("[TB] FAIL pout_rdwr_port2 got=%h exp=003c7e00", POUT_A);
    end
    tbIodbEnA = 1'b0;
    #1;
    testsRun++;
    if (IODB_A !== 8'hFF) begin
      testsFailed++; $display("[TB] FAIL rdwr_not_driven got=%h exp=ff", IODB_A);
    end
    busA.nPREQ = 1'b1; busA.nPRD = 1'b1; busA.nPWR = 1'b1;
    busB.IOAD = 2'd3; busB.nPREQ = 1'b0; busB.nPRD = 1'b0; busB.nPWR = 1'b1;
    #1;
    testsRun++;
    if (IODB_B !== 8'hFF) begin
      testsFailed++; $display("[TB] FAIL unmapped_read got=%h exp=ff", IODB_B);
    end
    busB.IOAD = 2'd0;
    #1;
    testsRun++;
    if (IODB_B !== 8'h5A) begin
      testsFailed++; $display("[TB] FAIL port0_b_read got=%h exp=5a", IODB_B);
    end
    busB.IOAD = 2'd3; busB.nPRD = 1'b1; busB.nPWR = 1'b0;
    tbIodbB = 8'h99; tbIodbEnB = 1'b1;
    tick();
    testsRun++;
    if (POUT_B !== 24'h0) begin
      testsFailed++; $display("[TB] FAIL unmapped_write got=%h exp=000000", POUT_B);
    end
    busB.nPREQ = 1'b1; busB.nPWR = 1'b1; tbIodbEnB = 1'b0;
    tick();
  endtask

  task automatic test_error();
    logic [15:0] d;
    int cyc;
    memWrite(1'b0, 16'h0006, 16'h1357, 2'b00, cyc);
    testsRun++;
    if (busA.ERR !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL err_before got=%b exp=0", busA.ERR);
    end
    driveData(1'b0, 1'b1, 16'hFFFF);
    driveMem(1'b0, 16'h0006, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    testsRun++;
    if (busA.ERR !== 1'b1 || busA.nREADY !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL err_set got err=%b nready=%b exp err=1 nready=1",
                              busA.ERR, busA.nREADY);
    end
    driveMem(1'b0, 16'h0006, 2'b11, 1'b1, 1'b1, 1'b1);
    driveData(1'b0, 1'b0, 16'h0000);
    tick();
    tick();
    memRead(1'b0, 16'h0006, 2'b00, d, cyc);
    testsRun++;
    if (d !== 16'h1357) begin
      testsFailed++; $display("[TB] FAIL err_ram_unchanged got=%h exp=1357", d);
    end
    testsRun++;
    if (busA.ERR !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL err_sticky got=%b exp=1", busA.ERR);
    end
  endtask

  task automatic test_reset_hold();
    logic [15:0] d;
    logic        inHold;
    int cyc;
    inHold = 1'b0;
    driveMem(1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busA.nREADY == 1'b0) begin
        inHold = 1'b1;
        break;
      end
    end
    d = DBUS_A;
    testsRun++;
    if (inHold !== 1'b1 || d !== 16'hBEEF) begin
      testsFailed++; $display("[TB] FAIL hold_before_reset got hold=%b dbus=%h exp hold=1 dbus=beef",
                              inHold, d);
    end
    #2;
    nRST = 1'b0;
    #1;
    d = DBUS_A;
    testsRun++;
    if (d !== 16'hFFFF || busA.nREADY !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL reset_in_hold got dbus=%h nready=%b exp dbus=ffff nready=1",
                              d, busA.nREADY);
    end
    testsRun++;
    if (POUT_A !== 32'h0 || busA.ERR !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL reset_pout_err got pout=%h err=%b exp pout=00000000 err=0",
                              POUT_A, busA.ERR);
    end
    driveMem(1'b0, 16'h0000, 2'b11, 1'b1, 1'b1, 1'b1);
    tick();
    nRST = 1'b1;
    tick();
    memRead(1'b0, 16'h0000, 2'b00, d, cyc);
    testsRun++;
    if (d !== 16'hBEEF || cyc !== 2) begin
      testsFailed++; $display("[TB] FAIL ram_retained got data=%h cyc=%0d exp data=beef cyc=2", d, cyc);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    nRST        = 1'b0;
    tbDbusA = 16'h0; tbDbusEnA = 1'b0; tbDbusB = 16'h0; tbDbusEnB = 1'b0;
    tbIodbA = 8'h0;  tbIodbEnA = 1'b0; tbIodbB = 8'h0;  tbIodbEnB = 1'b0;
    PIN_A = 32'h0;
    PIN_B = 24'h00_005A;
    driveMem(1'b0, 16'h0, 2'b11, 1'b1, 1'b1, 1'b1);
    driveMem(1'b1, 16'h0, 2'b11, 1'b1, 1'b1, 1'b1);
    busA.IOAD = 2'd0; busA.nPREQ = 1'b1; busA.nPRD = 1'b1; busA.nPWR = 1'b1;
    busB.IOAD = 2'd0; busB.nPREQ = 1'b1; busB.nPRD = 1'b1; busB.nPWR = 1'b1;

    test_reset();
    test_write_read();
    test_byte_lanes();
    test_wrap();
    test_abort();
    test_io();
    test_error();
    test_reset_hold();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
